// File: rtl/ps2_rx_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 receive decoder.
//               Prefix byte values, FSM state encoding, and a helper that
//               sizes the filter and timeout counters.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Scan-code prefix bytes that modify the next code instead of
    // producing an event of their own.
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // Frame receive state machine.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2State_t;

    // Width of a counter that runs from 0 to maxCount-1.
    function automatic int cntWidth(input int maxCount);
        return (maxCount < 2) ? 1 : $clog2(maxCount);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_decoder_if
// Description : Bundle between the PS/2 pads and the keyboard event consumer.
//               ps2Clk/ps2Data  - raw asynchronous pad levels
//               ps2OutCode      - scan code of the last event (held)
//               codeValid       - one-cycle event strobe
//               codeBreak       - key release flag, valid with codeValid
//               codeExt         - extended key flag, valid with codeValid
//               frameErr        - one-cycle parity/stop/timeout error strobe
//               master: drives the pads, observes events
//               slave : the decoder
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_rx_decoder_if;

    logic       ps2Clk;
    logic       ps2Data;
    logic [7:0] ps2OutCode;
    logic       codeValid;
    logic       codeBreak;
    logic       codeExt;
    logic       frameErr;

    modport master (
        output ps2Clk, ps2Data,
        input  ps2OutCode, codeValid, codeBreak, codeExt, frameErr
    );

    modport slave (
        input  ps2Clk, ps2Data,
        output ps2OutCode, codeValid, codeBreak, codeExt, frameErr
    );

endinterface
`default_nettype wire

// File: rtl/ps2_rx_decoder_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_filter
// Description : Pad conditioning for the PS/2 lines.
//               Two-flop synchronisers on clock and data, a glitch filter on
//               the clock, and a registered falling-edge pulse of the
//               filtered clock.
// Ports       : clk         - system clock
//               rst         - synchronous active-high reset
//               i_ps2Clk    - raw clock pad
//               i_ps2Data   - raw data pad
//               o_fallEdge  - one-cycle pulse per filtered clock 1->0
//               o_dataSync  - synchronised data line
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ps2Clk,
    input  wire logic i_ps2Data,
    output logic      o_fallEdge,
    output logic      o_dataSync
);

    localparam int              C_CW      = cntWidth(FILTER_LEN);
    localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(FILTER_LEN - 1);

    logic            r_clkMeta;
    logic            r_clkSync;
    logic            r_dataMeta;
    logic            r_dataSync;
    logic            r_filtClk;
    logic            r_filtDly;
    logic            r_fallEdge;
    logic [C_CW-1:0] r_filtCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_dataMeta <= 1'b1;
            r_dataSync <= 1'b1;
            r_filtClk  <= 1'b1;
            r_filtDly  <= 1'b1;
            r_fallEdge <= 1'b0;
            r_filtCnt  <= '0;
        end else begin
            r_clkMeta  <= i_ps2Clk;
            r_clkSync  <= r_clkMeta;
            r_dataMeta <= i_ps2Data;
            r_dataSync <= r_dataMeta;

            // Any cycle where the synced clock agrees with the filtered one
            // restarts the count, so only an uninterrupted run of
            // FILTER_LEN disagreeing cycles moves the filtered clock.
            if (r_clkSync == r_filtClk) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == C_CNT_MAX) begin
                r_filtClk <= r_clkSync;
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + C_CW'(1);
            end

            r_filtDly  <= r_filtClk;
            r_fallEdge <= r_filtDly & ~r_filtClk;
        end
    end

    assign o_fallEdge = r_fallEdge;
    assign o_dataSync = r_dataSync;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_decoder
// Description : PS/2 keyboard frame receiver and scan-code event generator.
//               Checks start/parity/stop, aborts stalled frames, folds the
//               F0 (break) and E0 (extended) prefixes into flags and emits
//               one event per non-prefix byte.
// Ports       : pixelClk - system clock, rising edge
//               reset    - synchronous active-high reset
//               bus      - slave side of ps2_rx_decoder_if (pads in,
//                          event/error strobes out)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  wire logic        pixelClk,
    input  wire logic        reset,
    ps2_rx_decoder_if.slave  bus
);

    localparam int                C_TO_W   = cntWidth(TIMEOUT);
    localparam logic [C_TO_W-1:0] C_TO_MAX = C_TO_W'(TIMEOUT - 1);

    logic w_fallEdge;
    logic w_data;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk        (pixelClk),
        .rst        (reset),
        .i_ps2Clk   (bus.ps2Clk),
        .i_ps2Data  (bus.ps2Data),
        .o_fallEdge (w_fallEdge),
        .o_dataSync (w_data)
    );

    ps2State_t         r_state,     w_state;
    logic [2:0]        r_bitCnt,    w_bitCnt;
    logic [7:0]        r_shift,     w_shift;
    logic              r_parity,    w_parity;
    logic              r_brkFlag,   w_brkFlag;
    logic              r_extFlag,   w_extFlag;
    logic [C_TO_W-1:0] r_toCnt,     w_toCnt;
    logic [7:0]        r_code,      w_code;
    logic              r_codeBreak, w_codeBreak;
    logic              r_codeExt,   w_codeExt;
    logic              r_valid,     w_valid;
    logic              r_err,       w_err;

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_brkFlag   <= 1'b0;
            r_extFlag   <= 1'b0;
            r_toCnt     <= '0;
            r_code      <= '0;
            r_codeBreak <= 1'b0;
            r_codeExt   <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bitCnt    <= w_bitCnt;
            r_shift     <= w_shift;
            r_parity    <= w_parity;
            r_brkFlag   <= w_brkFlag;
            r_extFlag   <= w_extFlag;
            r_toCnt     <= w_toCnt;
            r_code      <= w_code;
            r_codeBreak <= w_codeBreak;
            r_codeExt   <= w_codeExt;
            r_valid     <= w_valid;
            r_err       <= w_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_bitCnt    = r_bitCnt;
        w_shift     = r_shift;
        w_parity    = r_parity;
        w_brkFlag   = r_brkFlag;
        w_extFlag   = r_extFlag;
        w_toCnt     = r_toCnt;
        w_code      = r_code;
        w_codeBreak = r_codeBreak;
        w_codeExt   = r_codeExt;
        w_valid     = 1'b0;
        w_err       = 1'b0;

        if (r_state == IDLE) begin
            w_toCnt = '0;
            // A high level at a falling edge is not a start bit.
            if (w_fallEdge && !w_data) begin
                w_state  = DATA;
                w_bitCnt = '0;
            end
        end else if (!w_fallEdge) begin
            // Stalled mid-frame: abandon the frame and any pending prefix.
            if (r_toCnt == C_TO_MAX) begin
                w_state   = IDLE;
                w_toCnt   = '0;
                w_err     = 1'b1;
                w_brkFlag = 1'b0;
                w_extFlag = 1'b0;
            end else begin
                w_toCnt = r_toCnt + C_TO_W'(1);
            end
        end else begin
            w_toCnt = '0;
            case (r_state)
                DATA: begin
                    // LSB arrives first, so shift in from the top.
                    w_shift  = {w_data, r_shift[7:1]};
                    w_bitCnt = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_state = PARITY;
                    end
                end
                PARITY: begin
                    w_parity = w_data;
                    w_state  = STOP;
                end
                STOP: begin
                    w_state = IDLE;
                    if (((^{r_shift, r_parity}) == 1'b0) || !w_data) begin
                        w_err     = 1'b1;
                        w_brkFlag = 1'b0;
                        w_extFlag = 1'b0;
                    end else if (r_shift == PS2_BREAK) begin
                        w_brkFlag = 1'b1;
                    end else if (r_shift == PS2_EXT) begin
                        w_extFlag = 1'b1;
                    end else begin
                        w_code      = r_shift;
                        w_codeBreak = r_brkFlag;
                        w_codeExt   = r_extFlag;
                        w_valid     = 1'b1;
                        w_brkFlag   = 1'b0;
                        w_extFlag   = 1'b0;
                    end
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign bus.ps2OutCode = r_code;
    assign bus.codeValid  = r_valid;
    assign bus.codeBreak  = r_codeBreak;
    assign bus.codeExt    = r_codeExt;
    assign bus.frameErr   = r_err;

endmodule
`default_nettype wire

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
Receives raw PS/2 keyboard frames on the ps2Clk/ps2Data pins and turns them into one event per key action for the keyboard input decoder. Each event carries the scan code plus break and extended flags. The block sits between the pad inputs and inputDecode, and runs entirely in the pixelClk domain. It synchronises and deglitches the pins, checks the frame, strips the 0xF0/0xE0 prefix bytes, and reports errors.

Parameters:
FILTER_LEN, 8, consecutive pixelClk cycles synced ps2Clk must hold a new level before the filtered clock follows it.
TIMEOUT, 50000, pixelClk cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 25 MHz).

Ports:
pixelClk  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
ps2Clk  input  1  raw PS/2 clock pin, asynchronous.
ps2Data  input  1  raw PS/2 data pin, asynchronous.
ps2OutCode  output  8  scan code of the last event; held until the next event.
codeValid  output  1  one-cycle strobe: a new event is on ps2OutCode/codeBreak/codeExt.
codeBreak  output  1  event is a key release (0xF0 prefix seen); valid with codeValid, held after it.
codeExt  output  1  event is extended (0xE0 prefix seen); valid with codeValid, held after it.
frameErr  output  1  one-cycle strobe on a parity, stop-bit or timeout error.

Behaviour:
- Reset: all outputs 0, filtered clock 1, state IDLE, bit counter 0, prefix flags 0, timeout counter 0. Reset mid-frame discards the partial frame and produces no strobe.
- Input conditioning:
  - 2-FF synchronisers on both pins.
  - Filtered clock toggles only after synced ps2Clk differs from it for FILTER_LEN consecutive cycles; shorter pulses are ignored.
  - fallEdge is a registered one-cycle pulse when the filtered clock goes 1->0.
  - Data is sampled (synced ps2Data) in the fallEdge cycle.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM:
  - IDLE: on fallEdge with data 0 -> DATA, bitCnt=0. Data 1 at that edge is ignored and the FSM stays in IDLE.
  - DATA: shift on each fallEdge; after the 8th bit -> PARITY.
  - PARITY: capture the parity bit on fallEdge -> STOP.
  - STOP: on fallEdge, check the frame and return to IDLE.
    - Error if the XOR of the 8 data bits and the parity bit is 0, or if stop=0. On error: frameErr=1 for one cycle, no codeValid, prefix flags cleared.
    - Otherwise go to the code layer.
- Timeout:
  - Counter runs in DATA/PARITY/STOP and clears on every fallEdge.
  - Reaching TIMEOUT -> IDLE, frameErr pulse, prefix flags cleared.
  - Counter is held at 0 in IDLE.
- Code layer (on a good byte B):
  - B=0xF0: set the break flag, no output.
  - B=0xE0: set the ext flag, no output.
  - Any other byte, including 0xE1, 0xFA and 0xAA:
    - ps2OutCode<=B, codeBreak<=break flag, codeExt<=ext flag, codeValid<=1 for one cycle.
    - Both flags then clear.
- Latency: codeValid/frameErr rise exactly 1 pixelClk cycle after the fallEdge cycle of the stop bit.
  - Pin-to-fallEdge latency is 2 synchroniser cycles + FILTER_LEN + 1.
- Strobes never overlap. At most one event per frame.
- Repeated prefixes (F0 F0) keep the flag set. Prefixes persist across frames until a non-prefix byte or an error.

Decomposition:
- Shared package ps2_pkg:
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0;
  - FSM state encoding (IDLE, DATA, PARITY, STOP);
  - helper constant for the counter widths derived from FILTER_LEN/TIMEOUT.
- One sub-module, ps2_line_filter: 2-FF synchroniser plus glitch filter plus falling-edge pulse for ps2Clk. The data line uses the synchroniser only.

Test Plan:
- Frame 0x1C with correct odd parity -> single codeValid, ps2OutCode=0x1C, codeBreak=0, codeExt=0, frameErr=0.
- Frames F0,1C -> no strobe after F0; one codeValid after 1C with codeBreak=1, codeExt=0; the following 0x1C frame gives codeBreak=0.
- Frames E0,F0,75 -> exactly one codeValid, ps2OutCode=0x75, codeBreak=1, codeExt=1.
- Prefix then error: F0, then 0x16 with wrong parity -> frameErr pulse, no codeValid; next 0x16 good frame -> codeBreak=0.
- Timeout and recovery: 5 bits then silence for TIMEOUT+1 cycles -> one frameErr, FSM back in IDLE; a good 0x29 frame then yields codeValid with 0x29.
- Noise and reset: a 3-cycle ps2Clk low glitch in IDLE -> no state change; reset asserted after bit 4 of a frame -> all outputs 0, no strobe; next full 0x5A frame decodes correctly.
